stereo_pair_sync: RTL and testbench

STEREO_PAIR_SYNC -- requirements
Module: stereo_pair_sync

---
 rtl/stereo_pair_sync_pkg.sv | 29 ++
 rtl/stereo_pair_sync_pair_fifo.sv | 55 +++++
 rtl/stereo_pair_sync.sv | 145 ++++++++++++++
 tb/tb_stereo_pair_sync.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pair_sync_pkg.sv
// Shared stereo definitions: frame geometry defaults, field widths, the sample
// record carried through the pairing FIFOs, and the raster-index helper.
package stereo_pair_sync_pkg;

  localparam int ROW_SZ_DEF = 447;  // pixels per row
  localparam int COL_SZ_DEF = 370;  // rows per frame
  localparam int COORD_W    = 10;   // camera coordinate width
  localparam int PIX_W      = 8;    // pixel width
  localparam int IDX_W      = 18;   // raster index width, holds ROW_SZ*COL_SZ-1

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // One camera sample as stored in a side FIFO (28 bits).
  typedef struct packed {
    coord_t x;
    coord_t y;
    pix_t   val;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  // Raster position of a pixel within the frame: y*row_sz + x.
  function automatic idx_t raster_idx(coord_t x, coord_t y, idx_t row_sz);
    return idx_t'(y) * row_sz + idx_t'(x);
  endfunction

endpackage

// File: rtl/stereo_pair_sync_pair_fifo.sv
// pair_fifo: synchronous first-word-fall-through FIFO. The head word is visible
// on dout whenever empty is low. Pointers carry one extra bit so that full and
// empty are told apart; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module pair_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage write on accepted push.
  // NOTE: the array is deliberately not reset; the pointers alone decide which
  // entries are valid, so the storage stays a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer advance; wraps modulo DEPTH with the extra bit toggling on wrap.
  // NOTE: registers are updated with <= so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/stereo_pair_sync.sv
// stereo_pair_sync: pairs left and right camera samples by coordinate. Each
// side is range-checked and registered, then queued in its own pair_fifo. When
// both heads carry the same coordinate they pop together and the pair is
// registered onto the outputs; otherwise the older head is discarded and
// counted. Age comparison is by raster index, with frame wrap taken into account.
module stereo_pair_sync
  import stereo_pair_sync_pkg::*;
#(
  parameter int ROW_SZ = ROW_SZ_DEF,
  parameter int COL_SZ = COL_SZ_DEF,
  parameter int DEPTH  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] l_x,
  input  logic [COORD_W-1:0] l_y,
  input  logic [PIX_W-1:0]   l_val,
  input  logic               l_is_val,
  input  logic [COORD_W-1:0] r_x,
  input  logic [COORD_W-1:0] r_y,
  input  logic [PIX_W-1:0]   r_val,
  input  logic               r_is_val,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [PIX_W-1:0]   out_left,
  output logic [PIX_W-1:0]   out_right,
  output logic               out_is_val,
  output logic               overflow,
  output logic [15:0]        drop_cnt
);

  localparam coord_t ROW_LIM    = coord_t'(ROW_SZ);
  localparam coord_t COL_LIM    = coord_t'(COL_SZ);
  localparam idx_t   ROW_IDX    = idx_t'(ROW_SZ);
  localparam idx_t   HALF_FRAME = idx_t'((ROW_SZ * COL_SZ) / 2);

  sample_t l_in_q, r_in_q;
  logic    l_in_vld_q, r_in_vld_q;
  sample_t l_head, r_head;
  logic    l_full, l_empty, r_full, r_empty;
  logic    l_pop, r_pop;
  logic    match, mismatch, left_older;
  idx_t    idx_l, idx_r, idx_diff;

  // Input stage: keep only strobed samples that lie inside the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_in_vld_q <= 1'b0;
      r_in_vld_q <= 1'b0;
      l_in_q     <= '0;
      r_in_q     <= '0;
    end else begin
      l_in_vld_q <= l_is_val && (l_x < ROW_LIM) && (l_y < COL_LIM);
      r_in_vld_q <= r_is_val && (r_x < ROW_LIM) && (r_y < COL_LIM);
      l_in_q     <= '{x: l_x, y: l_y, val: l_val};
      r_in_q     <= '{x: r_x, y: r_y, val: r_val};
    end
  end

  pair_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_left_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (l_in_vld_q),
    .din   (l_in_q),
    .pop   (l_pop),
    .dout  (l_head),
    .full  (l_full),
    .empty (l_empty)
  );

  pair_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_right_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_in_vld_q),
    .din   (r_in_q),
    .pop   (r_pop),
    .dout  (r_head),
    .full  (r_full),
    .empty (r_empty)
  );

  // Head comparison: pair on equal coordinates, else retire the older head.
  always_comb begin
    // NOTE: each signal driven here gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    l_pop    = 1'b0;
    r_pop    = 1'b0;
    match    = 1'b0;
    mismatch = 1'b0;
    idx_l    = raster_idx(l_head.x, l_head.y, ROW_IDX);
    idx_r    = raster_idx(r_head.x, r_head.y, ROW_IDX);
    idx_diff = (idx_l >= idx_r) ? (idx_l - idx_r) : (idx_r - idx_l);
    // A gap wider than half a frame means the smaller index already wrapped.
    left_older = (idx_diff > HALF_FRAME) ? (idx_l > idx_r) : (idx_l < idx_r);
    if (!l_empty && !r_empty) begin
      if ((l_head.x == r_head.x) && (l_head.y == r_head.y)) begin
        match = 1'b1;
        l_pop = 1'b1;
        r_pop = 1'b1;
      end else begin
        mismatch = 1'b1;
        l_pop    = left_older;
        r_pop    = !left_older;
      end
    end
  end

  // Pair register: capture matched heads and hold them between pairs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_is_val <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_left   <= '0;
      out_right  <= '0;
    end else begin
      out_is_val <= match;
      if (match) begin
        out_x     <= l_head.x;
        out_y     <= l_head.y;
        out_left  <= l_head.val;
        out_right <= r_head.val;
      end
    end
  end

  // Sticky flag: a registered sample met a full FIFO that did not pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((l_in_vld_q && l_full && !l_pop) || (r_in_vld_q && r_full && !r_pop)) begin
      overflow <= 1'b1;
    end
  end

  // Saturating count of heads discarded for lack of a partner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (mismatch && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_stereo_pair_sync.sv
// Bench for stereo_pair_sync: a hand-written vector table for aligned streams,
// directed multi-cycle sequences for skew, mismatch, frame wrap, reset and
// overflow, and randomized streams checked every cycle against a queue-based
// reference model of the pairing rules.
module tb_stereo_pair_sync;

  localparam int ROW   = 447;
  localparam int COL   = 370;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] l_x, l_y, r_x, r_y;
  logic [7:0] l_val, r_val;
  logic       l_is_val, r_is_val;
  logic [9:0] out_x, out_y;
  logic [7:0] out_left, out_right;
  logic       out_is_val, overflow;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  stereo_pair_sync #(.ROW_SZ(ROW), .COL_SZ(COL), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .l_x        (l_x),
    .l_y        (l_y),
    .l_val      (l_val),
    .l_is_val   (l_is_val),
    .r_x        (r_x),
    .r_y        (r_y),
    .r_val      (r_val),
    .r_is_val   (r_is_val),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_is_val (out_is_val),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dut_pairs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int v; } smp_t;
  smp_t lq[$], rq[$];
  smp_t lp, rp;
  bit   lp_v, rp_v;
  int   m_val, m_x, m_y, m_l, m_r, m_ovf, m_drop;

  function automatic void model_reset();
    lq.delete(); rq.delete();
    lp_v = 0; rp_v = 0;
    m_val = 0; m_x = 0; m_y = 0; m_l = 0; m_r = 0; m_ovf = 0; m_drop = 0;
  endfunction

  function automatic bit left_is_older(int il, int ir);
    int d;
    d = (il > ir) ? il - ir : ir - il;
    if (d > (ROW * COL) / 2) return il > ir;
    return il < ir;
  endfunction

  // One clock edge: pair or retire heads, then accept last cycle's samples,
  // then sample this cycle's inputs.
  function automatic void model_edge();
    m_val = 0;
    if (lq.size() > 0 && rq.size() > 0) begin
      if (lq[0].x == rq[0].x && lq[0].y == rq[0].y) begin
        m_val = 1; m_x = lq[0].x; m_y = lq[0].y; m_l = lq[0].v; m_r = rq[0].v;
        void'(lq.pop_front());
        void'(rq.pop_front());
      end else begin
        if (left_is_older(lq[0].y * ROW + lq[0].x, rq[0].y * ROW + rq[0].x))
          void'(lq.pop_front());
        else
          void'(rq.pop_front());
        if (m_drop < 65535) m_drop++;
      end
    end
    if (lp_v) begin
      if (lq.size() < DEPTH) lq.push_back(lp); else m_ovf = 1;
    end
    if (rp_v) begin
      if (rq.size() < DEPTH) rq.push_back(rp); else m_ovf = 1;
    end
    lp_v = (l_is_val === 1'b1) && (l_x < ROW) && (l_y < COL);
    rp_v = (r_is_val === 1'b1) && (r_x < ROW) && (r_y < COL);
    lp = '{int'(l_x), int'(l_y), int'(l_val)};
    rp = '{int'(r_x), int'(r_y), int'(r_val)};
  endfunction

  task automatic compare_all();
    check("out_is_val", 32'(out_is_val), m_val);
    check("out_x",      32'(out_x),      m_x);
    check("out_y",      32'(out_y),      m_y);
    check("out_left",   32'(out_left),   m_l);
    check("out_right",  32'(out_right),  m_r);
    check("overflow",   32'(overflow),   m_ovf);
    check("drop_cnt",   32'(drop_cnt),   m_drop);
  endtask

  // Drive one cycle of stimulus, clock it, advance the model, compare.
  task automatic step(input bit ls, input int lx, input int ly, input int lv,
                      input bit rs, input int rx, input int ry, input int rv);
    l_is_val = ls; l_x = 10'(lx); l_y = 10'(ly); l_val = 8'(lv);
    r_is_val = rs; r_x = 10'(rx); r_y = 10'(ry); r_val = 8'(rv);
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
    if (out_is_val === 1'b1) dut_pairs++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ls; int lx; int ly; int lv;
    bit rs; int rx; int ry; int rv;
    bit ev; int ex; int el; int er;
  } vec_t;
  vec_t tbl[7];

  int p0, d0;

  initial begin
    // Aligned stream (0,0)..(3,0): pairs appear on the 2nd edge after sampling.
    tbl[0] = '{1, 0, 0, 10, 1, 0, 0, 20, 0, 0,  0,  0};
    tbl[1] = '{1, 1, 0, 11, 1, 1, 0, 21, 0, 0,  0,  0};
    tbl[2] = '{1, 2, 0, 12, 1, 2, 0, 22, 1, 0, 10, 20};
    tbl[3] = '{1, 3, 0, 13, 1, 3, 0, 23, 1, 1, 11, 21};
    tbl[4] = '{0, 0, 0,  0, 0, 0, 0,  0, 1, 2, 12, 22};
    tbl[5] = '{0, 0, 0,  0, 0, 0, 0,  0, 1, 3, 13, 23};
    tbl[6] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 3, 13, 23};

    model_reset();
    reset = 1'b1;
    l_is_val = 0; r_is_val = 0; l_x = 0; l_y = 0; r_x = 0; r_y = 0; l_val = 0; r_val = 0;
    idle(2);
    check("rst_out_is_val", 32'(out_is_val), 0);
    check("rst_overflow",   32'(overflow),   0);
    check("rst_drop_cnt",   32'(drop_cnt),   0);
    check("rst_out_x",      32'(out_x),      0);
    reset = 1'b0;

    // Table-driven aligned run.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].ls, tbl[i].lx, tbl[i].ly, tbl[i].lv, tbl[i].rs, tbl[i].rx, tbl[i].ry, tbl[i].rv);
      check("tbl_is_val", 32'(out_is_val), 32'(tbl[i].ev));
      check("tbl_x",      32'(out_x),      tbl[i].ex);
      check("tbl_y",      32'(out_y),      0);
      check("tbl_left",   32'(out_left),   tbl[i].el);
      check("tbl_right",  32'(out_right),  tbl[i].er);
    end
    check("tbl_drop_cnt", 32'(drop_cnt), 0);

    // Skew: right lags left by 5 cycles over 20 pixels.
    p0 = dut_pairs; d0 = int'(drop_cnt);
    for (int c = 0; c < 25; c++)
      step(c < 20, c, 1, c + 1, c >= 5, c - 5, 1, c + 100);
    idle(4);
    check("skew_pairs",    32'(dut_pairs - p0), 20);
    check("skew_overflow", 32'(overflow), 0);
    check("skew_drops",    32'(int'(drop_cnt) - d0), 0);

    // Mismatch: left (5,0),(6,0), right (6,0); left (5,0) discarded.
    p0 = dut_pairs; d0 = int'(drop_cnt);
    step(1, 5, 0, 50, 1, 6, 0, 60);
    step(1, 6, 0, 51, 0, 0, 0, 0);
    idle(4);
    check("mis_drops", 32'(int'(drop_cnt) - d0), 1);
    check("mis_pairs", 32'(dut_pairs - p0), 1);
    check("mis_x",     32'(out_x), 6);
    check("mis_left",  32'(out_left), 51);
    check("mis_right", 32'(out_right), 60);

    // Frame wrap: left (446,369) older than right (0,0); right retained.
    p0 = dut_pairs; d0 = int'(drop_cnt);
    step(1, 446, 369, 70, 1, 0, 0, 80);
    step(1, 0, 0, 71, 0, 0, 0, 0);
    idle(4);
    check("wrap_drops", 32'(int'(drop_cnt) - d0), 1);
    check("wrap_pairs", 32'(dut_pairs - p0), 1);
    check("wrap_xy",    32'({out_x, out_y}), 0);
    check("wrap_left",  32'(out_left), 71);
    check("wrap_right", 32'(out_right), 80);

    // Randomized raster streams with gaps, skips and out-of-frame samples.
    begin
      int li, ri, lx, ly, rx, ry;
      bit go, ls, rs;
      li = 440; ri = 440;
      p0 = dut_pairs;
      for (int c = 0; c < 400; c++) begin
        go = ($urandom_range(0, 3) != 0);
        ls = go && ($urandom_range(0, 9) != 0);
        rs = go && ($urandom_range(0, 9) != 0);
        if (ls && $urandom_range(0, 11) == 0) li++;
        if (rs && $urandom_range(0, 11) == 0) ri++;
        lx = li % ROW; ly = li / ROW;
        rx = ri % ROW; ry = ri / ROW;
        if (ls && $urandom_range(0, 15) == 0) lx = 500;
        if (rs && $urandom_range(0, 15) == 0) ry = 600;
        step(ls, lx, ly, int'($urandom_range(0, 255)), rs, rx, ry, int'($urandom_range(0, 255)));
        if (ls) li++;
        if (rs) ri++;
      end
      idle(40);
      check("rand_pairs_seen", 32'(dut_pairs - p0 > 50), 1);
    end

    // Reset mid-stream: outputs clear without a clock edge, samples during
    // reset are lost, the next aligned pair has 2-cycle latency.
    for (int i = 0; i < 8; i++) step(1, i, 2, 90 + i, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    check("arst_is_val",   32'(out_is_val), 0);
    check("arst_xy",       32'({out_x, out_y}), 0);
    check("arst_pix",      32'({out_left, out_right}), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_drop_cnt", 32'(drop_cnt), 0);
    model_reset();
    step(1, 9, 3, 1, 1, 9, 3, 2);
    reset = 1'b0;
    step(1, 5, 3, 33, 1, 5, 3, 44);
    check("lat_edge0", 32'(out_is_val), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("lat_edge1", 32'(out_is_val), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("lat_edge2",  32'(out_is_val), 1);
    check("lat_x",      32'(out_x), 5);
    check("lat_left",   32'(out_left), 33);
    check("lat_right",  32'(out_right), 44);
    idle(3);
    check("rst_lost_drops", 32'(drop_cnt), 0);

    // Overflow: 17 left pushes into a 16-deep FIFO, then 16 right matches.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step(1, i, 4, i, 0, 0, 0, 0);
    idle(3);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_drops", 32'(drop_cnt), 0);
    p0 = dut_pairs;
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, i, 4, 100 + i);
    idle(4);
    check("ovf_pairs", 32'(dut_pairs - p0), 16);
    check("ovf_last_x", 32'(out_x), 15);
    check("ovf_last_l", 32'(out_left), 15);
    check("ovf_last_r", 32'(out_right), 115);
    step(0, 0, 0, 0, 1, 16, 4, 7);
    idle(4);
    check("ovf_lost_entry", 32'(dut_pairs - p0), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
